// File: rtl/bram_arb_pkg.sv
// Shared constants for the BRAM port-A arbiter: FSM state encoding and master indices.
package bram_arb_pkg;

    localparam logic [1:0] ST_OPEN  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    localparam int M_CPU = 0;
    localparam int M_DMA = 1;

endpackage

// File: rtl/bram_arb_pick2.sv
// Combinational 2-way grant picker; round-robin ties when BRAM_ARB_RR_EN is defined,
// otherwise fixed priority with m0 winning ties.
module bram_arb_pick2
    import bram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] state,
    output logic [1:0] gnt
);

`ifndef BRAM_ARB_RR_EN
    logic unused_last_s;
    assign unused_last_s = last;
`endif

    // Grant selection from current requests and lock state
    always_comb begin
        gnt = 2'b00;
        case (state)
            ST_OPEN: begin
                if (req == 2'b11) begin
`ifdef BRAM_ARB_RR_EN
                    // Tie goes to whoever did not win last
                    if (last) begin
                        gnt = 2'b01;
                    end else begin
                        gnt = 2'b10;
                    end
`else
                    gnt = 2'b01;
`endif
                end else begin
                    gnt = req;
                end
            end
            ST_LOCK0: gnt = {1'b0, req[M_CPU]};
            ST_LOCK1: gnt = {req[M_DMA], 1'b0};
            default:  gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-master arbiter for port A of a synchronous dual-port BRAM, with optional burst lock.
// Build option: define BRAM_ARB_RR_EN for round-robin tie breaking (fixed m0 priority otherwise).
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int DATA = 8,
    parameter int ADDR = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_req,
    input  logic            m0_lock,
    input  logic            m0_we,
    input  logic [ADDR-1:0] m0_addr,
    input  logic [DATA-1:0] m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DATA-1:0] m0_rdata,
    input  logic            m1_req,
    input  logic            m1_lock,
    input  logic            m1_we,
    input  logic [ADDR-1:0] m1_addr,
    input  logic [DATA-1:0] m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DATA-1:0] m1_rdata,
    output logic            ram_we,
    output logic [ADDR-1:0] ram_addr,
    output logic [DATA-1:0] ram_write,
    input  logic [DATA-1:0] ram_read
);

    logic [1:0] state_r;
    logic       last_grant_r;
    logic       rvalid0_r;
    logic       rvalid1_r;
    logic [1:0] pick_s;
    logic       acc0_s;
    logic       acc1_s;

    bram_arb_pick2 u_pick (
        .req   ({m1_req, m0_req}),
        .last  (last_grant_r),
        .state (state_r),
        .gnt   (pick_s)
    );

    // Grants are suppressed combinationally while reset is asserted
    assign m0_gnt = pick_s[M_CPU] & rst_n;
    assign m1_gnt = pick_s[M_DMA] & rst_n;
    assign acc0_s = m0_req & m0_gnt;
    assign acc1_s = m1_req & m1_gnt;

    // Lock FSM: an accepted beat decides whether its master keeps the port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_OPEN;
        end else if (acc0_s) begin
            state_r <= m0_lock ? ST_LOCK0 : ST_OPEN;
        end else if (acc1_s) begin
            state_r <= m1_lock ? ST_LOCK1 : ST_OPEN;
        end else begin
            state_r <= state_r;
        end
    end

    // Remember the most recent winner for round-robin tie breaking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if (acc0_s) begin
            last_grant_r <= 1'b0;
        end else if (acc1_s) begin
            last_grant_r <= 1'b1;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Read data appears one cycle after the accepting edge (RAM registers the address)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
        end else begin
            rvalid0_r <= acc0_s & ~m0_we;
            rvalid1_r <= acc1_s & ~m1_we;
        end
    end

    assign m0_rvalid = rvalid0_r;
    assign m1_rvalid = rvalid1_r;
    assign m0_rdata  = ram_read;
    assign m1_rdata  = ram_read;

    // Port mux: idle cycles park the address on m0 with writes disabled
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = m0_addr;
        ram_write = m0_wdata;
        if (m1_gnt) begin
            ram_we    = m1_we;
            ram_addr  = m1_addr;
            ram_write = m1_wdata;
        end else if (m0_gnt) begin
            ram_we    = m0_we;
            ram_addr  = m0_addr;
            ram_write = m0_wdata;
        end else begin
            ram_we    = 1'b0;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter with a behavioural registered-address RAM.
module tb_bram_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic       m0_req, m0_lock, m0_we, m0_gnt, m0_rvalid;
    logic [9:0] m0_addr;
    logic [7:0] m0_wdata, m0_rdata;
    logic       m1_req, m1_lock, m1_we, m1_gnt, m1_rvalid;
    logic [9:0] m1_addr;
    logic [7:0] m1_wdata, m1_rdata;
    logic       ram_we;
    logic [9:0] ram_addr;
    logic [7:0] ram_write, ram_read;

    int errors = 0;
    int checks = 0;

    bram_port_arbiter #(.DATA(8), .ADDR(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_write(ram_write), .ram_read(ram_read)
    );

    // Behavioural model of the RAM's port A: write on edge, registered read address
    logic [7:0] mem [0:1023];
    logic [9:0] addr_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_write;
        addr_q <= ram_addr;
    end
    assign ram_read = mem[addr_q];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic req, input logic lock, input logic we,
                          input logic [9:0] addr, input logic [7:0] wd);
        m0_req = req; m0_lock = lock; m0_we = we; m0_addr = addr; m0_wdata = wd;
    endtask

    task automatic set_m1(input logic req, input logic lock, input logic we,
                          input logic [9:0] addr, input logic [7:0] wd);
        m1_req = req; m1_lock = lock; m1_we = we; m1_addr = addr; m1_wdata = wd;
    endtask

    logic exp_g1;

    initial begin
        rst_n = 1'b0;
        set_m0(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        set_m1(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        tick();
        set_m0(1'b1, 1'b0, 1'b0, 10'h010, 8'h00);
        set_m1(1'b1, 1'b0, 1'b0, 10'h020, 8'h00);
        #1;
        chk("rst_gnt0", {31'd0, m0_gnt}, 32'd0);
        chk("rst_gnt1", {31'd0, m1_gnt}, 32'd0);
        chk("rst_rvalid0", {31'd0, m0_rvalid}, 32'd0);
        tick();
        rst_n = 1'b1;
        // last_grant resets to 1, so m0 wins the first tie in either build
        #1;
        chk("tie_after_reset_g0", {31'd0, m0_gnt}, 32'd1);
        chk("tie_after_reset_g1", {31'd0, m1_gnt}, 32'd0);
        set_m0(1'b0, 1'b0, 1'b0, 10'h010, 8'h00);

        // Preload via m1 writes
        set_m1(1'b1, 1'b0, 1'b1, 10'h020, 8'h77);
        #1;
        chk("m1_zero_wait", {31'd0, m1_gnt}, 32'd1);
        tick();
        set_m1(1'b1, 1'b0, 1'b1, 10'h021, 8'h88);
        tick();
        chk("wr_no_rvalid1", {31'd0, m1_rvalid}, 32'd0);
        set_m1(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);

        // Test 1: m0 write then read 0x010
        set_m0(1'b1, 1'b0, 1'b1, 10'h010, 8'hA5);
        #1;
        chk("t1_wr_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("t1_ram_we", {31'd0, ram_we}, 32'd1);
        tick();
        chk("t1_wr_no_rvalid", {31'd0, m0_rvalid}, 32'd0);
        set_m0(1'b1, 1'b0, 1'b0, 10'h010, 8'h00);
        #1;
        chk("t1_rd_gnt", {31'd0, m0_gnt}, 32'd1);
        tick();
        set_m0(1'b0, 1'b0, 1'b0, 10'h010, 8'h00);
        chk("t1_rvalid", {31'd0, m0_rvalid}, 32'd1);
        chk("t1_rdata", {24'd0, m0_rdata}, 32'hA5);
        chk("t1_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
        tick();
        chk("t1_rvalid_drop", {31'd0, m0_rvalid}, 32'd0);

        // Test 2: both masters read continuously; last winner was m0
        set_m0(1'b1, 1'b0, 1'b0, 10'h010, 8'h00);
        set_m1(1'b1, 1'b0, 1'b0, 10'h020, 8'h00);
        for (int i = 0; i < 4; i++) begin
`ifdef BRAM_ARB_RR_EN
            exp_g1 = (i % 2 == 0);
`else
            exp_g1 = 1'b0;
`endif
            #1;
            chk("t2_gnt0", {31'd0, m0_gnt}, {31'd0, ~exp_g1});
            chk("t2_gnt1", {31'd0, m1_gnt}, {31'd0, exp_g1});
            tick();
            chk("t2_rvalid0", {31'd0, m0_rvalid}, {31'd0, ~exp_g1});
            chk("t2_rvalid1", {31'd0, m1_rvalid}, {31'd0, exp_g1});
            chk("t2_rdata", {24'd0, m0_rdata}, exp_g1 ? 32'h77 : 32'hA5);
        end
        set_m0(1'b0, 1'b0, 1'b0, 10'h010, 8'h00);
        set_m1(1'b0, 1'b0, 1'b0, 10'h020, 8'h00);
        tick();
        chk("t2_idle_rv0", {31'd0, m0_rvalid}, 32'd0);
        chk("t2_idle_rv1", {31'd0, m1_rvalid}, 32'd0);

        // Test 3: m1 locked burst with an idle lock cycle gap
        set_m1(1'b1, 1'b1, 1'b0, 10'h020, 8'h00);
        #1;
        chk("t3_lock_gnt1", {31'd0, m1_gnt}, 32'd1);
        tick();
        chk("t3_rv1", {31'd0, m1_rvalid}, 32'd1);
        chk("t3_rdata", {24'd0, m1_rdata}, 32'h77);
        set_m1(1'b0, 1'b0, 1'b0, 10'h020, 8'h00);
        set_m0(1'b1, 1'b0, 1'b0, 10'h010, 8'h00);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_idle_gnt0", {31'd0, m0_gnt}, 32'd0);
            chk("t3_idle_ram_we", {31'd0, ram_we}, 32'd0);
            chk("t3_idle_ram_addr", {22'd0, ram_addr}, 32'h010);
            tick();
        end
        set_m1(1'b1, 1'b0, 1'b0, 10'h021, 8'h00);
        #1;
        chk("t3_unlock_gnt1", {31'd0, m1_gnt}, 32'd1);
        chk("t3_unlock_gnt0", {31'd0, m0_gnt}, 32'd0);
        tick();
        set_m1(1'b0, 1'b0, 1'b0, 10'h021, 8'h00);
        chk("t3_unlock_rv1", {31'd0, m1_rvalid}, 32'd1);
        chk("t3_unlock_rdata", {24'd0, m1_rdata}, 32'h88);
        #1;
        chk("t3_m0_after", {31'd0, m0_gnt}, 32'd1);
        tick();
        chk("t3_m0_rv", {31'd0, m0_rvalid}, 32'd1);

        // Test 4: write at top address, immediate read by the other master
        set_m0(1'b1, 1'b0, 1'b1, 10'h3FF, 8'h3C);
        tick();
        set_m0(1'b0, 1'b0, 1'b0, 10'h010, 8'h00);
        set_m1(1'b1, 1'b0, 1'b0, 10'h3FF, 8'h00);
        #1;
        chk("t4_gnt1", {31'd0, m1_gnt}, 32'd1);
        chk("t4_ram_addr", {22'd0, ram_addr}, 32'h3FF);
        tick();
        set_m1(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        chk("t4_rv1", {31'd0, m1_rvalid}, 32'd1);
        chk("t4_raw_rdata", {24'd0, m1_rdata}, 32'h3C);

        // Test 5: reset while in LOCK0 with a read in flight
        set_m0(1'b1, 1'b1, 1'b0, 10'h010, 8'h00);
        tick();
        chk("t5_inflight", {31'd0, m0_rvalid}, 32'd1);
        rst_n = 1'b0;
        set_m1(1'b1, 1'b0, 1'b0, 10'h020, 8'h00);
        #1;
        chk("t5_rv_drop", {31'd0, m0_rvalid}, 32'd0);
        chk("t5_rst_gnt0", {31'd0, m0_gnt}, 32'd0);
        chk("t5_rst_gnt1", {31'd0, m1_gnt}, 32'd0);
        tick();
        chk("t5_rst_gnt1_b", {31'd0, m1_gnt}, 32'd0);
        set_m0(1'b0, 1'b0, 1'b0, 10'h010, 8'h00);
        rst_n = 1'b1;
        #1;
        chk("t5_m1_gnt", {31'd0, m1_gnt}, 32'd1);
        tick();
        set_m1(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        chk("t5_m1_rv", {31'd0, m1_rvalid}, 32'd1);
        chk("t5_m1_rdata", {24'd0, m1_rdata}, 32'h77);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
